// File: rtl/pc_redirect_sequencer_pkg.sv
// Shared CPU constants for the PC sequencer: widths, fetch stride, reset PC and state encoding.
package pc_redirect_sequencer_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned PC_STRIDE = 4;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } redirect_state_e;

endpackage

// File: rtl/pc_redirect_sequencer_pc_incrementer.sv
// Sequential successor adder (pc + instruction stride), kept apart so it can be shared later.
module pc_incrementer
  import pc_redirect_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);

  assign pc_next = pc + PC_W'(PC_STRIDE);

endmodule

// File: rtl/pc_redirect_sequencer.sv
// Architectural PC owner: sequential advance plus a one-entry buffered redirect slot
// committed on the control unit's pc_write strobe, with sticky misaligned-target capture.
module pc_redirect_sequencer
  import pc_redirect_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic            redirect_ready,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            redirect_pending,
  output logic            misalign_err,
  output logic [PC_W-1:0] err_target
);

  redirect_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;
  logic            misalign_err_q, misalign_err_d;
  logic [PC_W-1:0] err_target_q, err_target_d;

  logic accept;
  logic target_aligned;

  pc_incrementer u_pc_incrementer (
    .pc      (pc_q),
    .pc_next (pc_plus4)
  );

  // Slot frees in the same cycle it is consumed; no path from redirect_valid.
  assign redirect_ready = (state_q == ST_EMPTY) || pc_write;
  assign accept         = redirect_valid && redirect_ready;
  assign target_aligned = (redirect_target[1:0] == 2'b00);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_target_d  = pend_target_q;
    misalign_err_d = misalign_err_q;
    err_target_d   = err_target_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (pc_write) begin
          pc_d = (accept && target_aligned) ? redirect_target : pc_plus4;
        end else if (accept && target_aligned) begin
          pend_target_d = redirect_target;
          state_d       = ST_HELD;
        end
      end
      ST_HELD: begin
        if (pc_write) begin
          // Older buffered target always commits before a newly accepted one.
          pc_d = pend_target_q;
          if (accept && target_aligned) begin
            pend_target_d = redirect_target;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Misaligned targets complete the handshake but only record the error.
    if (accept && !target_aligned) begin
      misalign_err_d = 1'b1;
      if (!misalign_err_q) begin
        err_target_d = redirect_target;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= ST_EMPTY;
      pc_q           <= RESET_PC;
      pend_target_q  <= '0;
      misalign_err_q <= 1'b0;
      err_target_q   <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_target_q  <= pend_target_d;
      misalign_err_q <= misalign_err_d;
      err_target_q   <= err_target_d;
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = (state_q == ST_HELD);
  assign misalign_err     = misalign_err_q;
  assign err_target       = err_target_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Directed self-checking bench for pc_redirect_sequencer with hand-computed expectations.
module tb_pc_redirect_sequencer;

  logic        CLK;
  logic        RST;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_pending;
  logic        misalign_err;
  logic [31:0] err_target;

  int checks;
  int errors;

  pc_redirect_sequencer dut (
    .CLK              (CLK),
    .RST              (RST),
    .pc_write         (pc_write),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .redirect_ready   (redirect_ready),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .redirect_pending (redirect_pending),
    .misalign_err     (misalign_err),
    .err_target       (err_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic v, input logic [31:0] t);
    pc_write        = w;
    redirect_valid  = v;
    redirect_target = t;
    @(posedge CLK);
    #1;
    pc_write        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    pc_write        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    RST             = 1'b1;
    #12;
    check("rst_pc",       pc,               32'h0);
    check("rst_plus4",    pc_plus4,         32'h4);
    check("rst_pending",  redirect_pending, 32'h0);
    check("rst_ready",    redirect_ready,   32'h1);
    check("rst_err",      misalign_err,     32'h0);
    check("rst_errtgt",   err_target,       32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Sequential advance.
    step(1'b1, 1'b0, 32'h0); check("seq_pc1", pc, 32'h4);
    step(1'b1, 1'b0, 32'h0); check("seq_pc2", pc, 32'h8);
    step(1'b1, 1'b0, 32'h0); check("seq_pc3", pc, 32'hC);
    check("seq_plus4", pc_plus4, 32'h10);
    step(1'b1, 1'b0, 32'h0); check("seq_pc4", pc, 32'h10);

    // Buffered redirect.
    step(1'b0, 1'b1, 32'h40);
    check("buf_pc_hold",  pc,               32'h10);
    check("buf_pending",  redirect_pending, 32'h1);
    check("buf_ready0",   redirect_ready,   32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("buf_stall_pc", pc,               32'h10);
    pc_write = 1'b1;
    #1;
    check("buf_ready_w",  redirect_ready,   32'h1);
    step(1'b1, 1'b0, 32'h0);
    check("buf_commit",   pc,               32'h40);
    check("buf_clear",    redirect_pending, 32'h0);

    // Bypass.
    step(1'b1, 1'b1, 32'h20);
    check("byp_pc20",     pc,               32'h20);
    step(1'b1, 1'b1, 32'h100);
    check("byp_pc100",    pc,               32'h100);
    check("byp_pending",  redirect_pending, 32'h0);

    // HELD with simultaneous commit and new accept.
    step(1'b0, 1'b1, 32'h200);
    check("held_pend",    redirect_pending, 32'h1);
    step(1'b1, 1'b1, 32'h300);
    check("held_pc200",   pc,               32'h200);
    check("held_pend2",   redirect_pending, 32'h1);
    step(1'b1, 1'b0, 32'h0);
    check("held_pc300",   pc,               32'h300);
    check("held_clear",   redirect_pending, 32'h0);

    // Misaligned targets.
    step(1'b1, 1'b1, 32'h8);
    check("mis_pc8",      pc,               32'h8);
    check("mis_ready",    redirect_ready,   32'h1);
    step(1'b0, 1'b1, 32'h42);
    check("mis_err",      misalign_err,     32'h1);
    check("mis_errtgt",   err_target,       32'h42);
    check("mis_nopend",   redirect_pending, 32'h0);
    check("mis_pc_hold",  pc,               32'h8);
    step(1'b1, 1'b0, 32'h0);
    check("mis_pcC",      pc,               32'hC);
    step(1'b0, 1'b1, 32'h43);
    check("mis_sticky",   err_target,       32'h42);
    check("mis_nopend2",  redirect_pending, 32'h0);
    step(1'b1, 1'b1, 32'h45);
    check("mis_byp_pc",   pc,               32'h10);
    check("mis_byp_tgt",  err_target,       32'h42);
    check("mis_err_hold", misalign_err,     32'h1);

    // Wrap-around.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc",      pc,               32'hFFFF_FFFC);
    check("wrap_plus4",   pc_plus4,         32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_pc0",     pc,               32'h0);

    // Reset while HELD discards the buffered target.
    step(1'b1, 1'b1, 32'h1000);
    step(1'b0, 1'b1, 32'h80);
    check("rh_pend",      redirect_pending, 32'h1);
    RST = 1'b1;
    #1;
    check("rh_pend0",     redirect_pending, 32'h0);
    check("rh_pc",        pc,               32'h0);
    check("rh_err0",      misalign_err,     32'h0);
    @(negedge CLK);
    RST = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    check("rh_idle_pc",   pc,               32'h0);
    check("rh_idle_pend", redirect_pending, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("rh_pc4",       pc,               32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_sequencer.md
# pc_redirect_sequencer

Program-counter owner for the multicycle CPU. It holds the architectural PC, produces the sequential successor PC+4, and accepts branch/jump redirect targets from the branch-target adder through a valid/ready handshake. Accepted targets are buffered in a one-entry pending slot and committed on the control unit's PC-write strobe. Branch resolution (EXE state) can therefore occur cycles before the next fetch (IF state).

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous, active-high reset
- pc_write  input  1  one-cycle commit strobe from the control FSM (IF state)
- redirect_valid  input  1  redirect target offered
- redirect_target  input  32  byte address of the taken branch/jump target
- redirect_ready  output  1  sequencer can accept a redirect this cycle
- pc  output  32  current PC (registered)
- pc_plus4  output  32  pc + 4, combinational, modulo 2^32
- redirect_pending  output  1  a target is buffered and awaiting pc_write
- misalign_err  output  1  sticky: an accepted target had target[1:0] != 0
- err_target  output  32  first misaligned target accepted since reset

## Operation

- A redirect is accepted on a rising edge when redirect_valid && redirect_ready.
- redirect_ready = !redirect_pending || pc_write. The slot frees in the same cycle it is consumed.
- The FSM has two states:
  - EMPTY: redirect_pending = 0.
  - HELD: redirect_pending = 1; pend_target holds the buffered target.
- EMPTY transitions:
  - accept && !pc_write: store target, go to HELD; pc unchanged.
  - accept && pc_write: bypass. pc <= redirect_target; stay EMPTY.
  - pc_write without accept: pc <= pc_plus4.
- HELD transitions:
  - pc_write && !accept: pc <= pend_target, go to EMPTY.
  - pc_write && accept: pc <= pend_target; new target overwrites the slot; stay HELD. The older target commits first.
  - no pc_write: hold. redirect_ready = 0, so a new offer stalls.
- Misaligned targets (target[1:0] != 0):
  - The target is accepted (handshake completes) but never committed.
  - In EMPTY or bypass, pc advances as if no redirect arrived: pc <= pc_plus4 on pc_write.
  - The slot is not filled.
  - misalign_err is set. err_target captures the target only if misalign_err was 0.
- Arithmetic: 32-bit unsigned, wrap-around. pc = 32'hFFFF_FFFC gives pc_plus4 = 32'h0000_0000.

## Timing

- Reset (asynchronous, immediate):
  - pc = RESET_PC, state EMPTY, redirect_pending = 0, redirect_ready = 1, misalign_err = 0, err_target = 0.
  - pc_plus4 = RESET_PC + 4.
- pc updates one edge after a sampled pc_write. pc_plus4 follows pc in the same cycle with zero latency.
- Redirect commit latency:
  - Bypass: 1 edge.
  - Otherwise: the first pc_write edge after acceptance.
- redirect_ready is combinational from state and pc_write. No combinational path exists from redirect_valid to redirect_ready.
- RST asserted mid-HELD discards the pending target. No commit occurs after reset release without a new accept.
- Back-to-back pc_write strobes with no redirects advance pc by 4 per cycle.

## Structure

- The shared CPU package holds:
  - the PC width constant (32) and the instruction byte stride (4);
  - RESET_PC default;
  - the two-value state encoding (EMPTY = 1'b0, HELD = 1'b1).
- One sub-module is natural: pc_incrementer (combinational pc + stride). Keep it separate so the same adder can later be shared with the branch-target computation.
- All other logic (state register, pend_target, pc register, error capture) lives in the top module.

## Test plan

- Reset release, then 3 pc_write strobes, no redirects: pc goes 0x0 → 0x4 → 0x8 → 0xC.
- pc = 0x10; offer 0x40 with no pc_write; pending = 1, ready = 0. Next pc_write gives pc = 0x40, pending = 0.
- Bypass: EMPTY, pc = 0x20; redirect 0x100 and pc_write in the same cycle gives pc = 0x100 after 1 edge; pending stays 0.
- HELD with 0x200; pc_write plus new offer 0x300 in the same cycle gives pc = 0x200, pending = 1. Next pc_write gives pc = 0x300.
- Misaligned 0x42 offered in EMPTY, pc = 0x8: accepted, misalign_err = 1, err_target = 0x42. Next pc_write gives pc = 0xC. A later 0x43 leaves err_target = 0x42.
- Wrap and reset: pc = 0xFFFF_FFFC, pc_write gives pc = 0x0. Assert RST while HELD with 0x80: pending = 0, pc = RESET_PC. Next pc_write gives pc = RESET_PC + 4.
